pulse_stretch_multi: RTL and testbench

Multi-channel, runtime-programmable pulse stretcher, the successor to the fixed-length single-channel stretcher. Each of CHANNELS independent lanes turns a trigger event into an output pulse exactly Len clock cycles long. Per-lane capability added over the single-channel version:
- programmable length, including zero (disabled);
- rising-edge or level triggering;
- hold (non-retriggerable) or retrigger (extend) mode;
- one-cycle end-of-pulse strobe.

Sits between control/status logic and slow consumers (LEDs, strobes, handshake widening).

---
 rtl/pulse_stretch_multi.sv | 102 ++++++++++
 tb/tb_pulse_stretch_multi.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_stretch_multi.sv
// ---------------------------------------------------------------------------
// pulse_stretch_multi
//
// Multi-lane, runtime-programmable pulse stretcher. Each lane turns a trigger
// event into an output pulse exactly Len clock cycles long, followed by a
// one-cycle end-of-pulse strobe. The length and the two mode selects are
// shared by all lanes and are sampled only when a lane accepts a trigger.
//
// Parameters
//   CHANNELS        number of independent lanes (>= 1)
//   WIDTH           length / counter width, max pulse length 2^WIDTH-1
//
// Ports
//   clk             rising-edge clock
//   ares_L          asynchronous active-low reset
//   sres            synchronous clear of all lanes, active high
//   Len             pulse length in cycles (0 = triggers ignored)
//   Edge_H_Level_L  1 = rising-edge trigger, 0 = level trigger
//   Retrig_H_Hold_L 1 = retrigger reloads the count, 0 = hold
//   Trigger         per-lane trigger inputs
//   Q               per-lane stretched pulse (registered)
//   Done            per-lane one-cycle end strobe (registered)
// ---------------------------------------------------------------------------
module pulse_stretch_multi #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8
) (
    input  logic                clk,
    input  logic                ares_L,
    input  logic                sres,
    input  logic [WIDTH-1:0]    Len,
    input  logic                Edge_H_Level_L,
    input  logic                Retrig_H_Hold_L,
    input  logic [CHANNELS-1:0] Trigger,
    output logic [CHANNELS-1:0] Q,
    output logic [CHANNELS-1:0] Done
);

    logic [CHANNELS-1:0] r_active;
    logic [CHANNELS-1:0] r_prev;
    logic [CHANNELS-1:0] r_done;
    logic [WIDTH-1:0]    r_rem [CHANNELS];

    logic                w_lenNonZero;
    logic [CHANNELS-1:0] w_event;
    logic [CHANNELS-1:0] w_accept;

    assign w_lenNonZero = (Len != '0);

    // Trigger detection and acceptance per lane. A running pulse may still
    // accept a trigger in hold mode on its terminal cycle (Rem=0), which
    // chains the next pulse on with no low gap.
    always_comb begin
        w_event  = '0;
        w_accept = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_event[i]  = Edge_H_Level_L ? (Trigger[i] & ~r_prev[i]) : Trigger[i];
            w_accept[i] = w_event[i] & w_lenNonZero &
                          (~r_active[i] | (r_rem[i] == '0) | Retrig_H_Hold_L);
        end
    end

    // Per-lane pulse state. Rem holds the number of cycles still to run
    // after the current one, so an accept loads Len-1 and the pulse ends on
    // the edge that sees Rem=0. Prev keeps sampling Trigger even during the
    // synchronous clear so edge detection stays coherent afterwards.
    always_ff @(posedge clk or negedge ares_L) begin
        if (!ares_L) begin
            r_active <= '0;
            r_prev   <= '0;
            r_done   <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_rem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_prev[i] <= Trigger[i];
                if (sres) begin
                    r_active[i] <= 1'b0;
                    r_rem[i]    <= '0;
                    r_done[i]   <= 1'b0;
                end else if (w_accept[i]) begin
                    r_active[i] <= 1'b1;
                    r_rem[i]    <= Len - WIDTH'(1);
                    r_done[i]   <= 1'b0;
                end else if (r_active[i] && (r_rem[i] == '0)) begin
                    r_active[i] <= 1'b0;
                    r_done[i]   <= 1'b1;
                end else if (r_active[i]) begin
                    r_rem[i]    <= r_rem[i] - WIDTH'(1);
                    r_done[i]   <= 1'b0;
                end else begin
                    r_done[i]   <= 1'b0;
                end
            end
        end
    end

    assign Q    = r_active;
    assign Done = r_done;

endmodule

// File: tb/tb_pulse_stretch_multi.sv
// ---------------------------------------------------------------------------
// tb_pulse_stretch_multi
//
// Self-checking bench for pulse_stretch_multi. The reference model tracks,
// per lane, the clock count at which the current pulse ends: Q is high while
// the cycle count is below that end point, and Done fires on the cycle that
// reaches it naturally. Directed scenarios additionally count observed high
// cycles and Done strobes and compare them with fixed expected widths.
// ---------------------------------------------------------------------------
module tb_pulse_stretch_multi;

    localparam int CH = 4;
    localparam int W  = 8;

    logic          clk;
    logic          ares_L;
    logic          sres;
    logic [W-1:0]  Len;
    logic          Edge_H_Level_L;
    logic          Retrig_H_Hold_L;
    logic [CH-1:0] Trigger;
    logic [CH-1:0] Q;
    logic [CH-1:0] Done;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int cycleNum = 0;
    int endCycle [CH];
    bit prevModel [CH];
    bit doneModel [CH];

    // Observed activity counters for directed width checks
    int hiCnt [CH];
    int doneCnt [CH];

    pulse_stretch_multi #(
        .CHANNELS(CH),
        .WIDTH(W)
    ) dut (
        .clk(clk),
        .ares_L(ares_L),
        .sres(sres),
        .Len(Len),
        .Edge_H_Level_L(Edge_H_Level_L),
        .Retrig_H_Hold_L(Retrig_H_Hold_L),
        .Trigger(Trigger),
        .Q(Q),
        .Done(Done)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point for the whole bench
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < CH; i++) begin
            endCycle[i]  = 0;
            prevModel[i] = 1'b0;
            doneModel[i] = 1'b0;
        end
    endtask

    task automatic clearCounts();
        for (int i = 0; i < CH; i++) begin
            hiCnt[i]   = 0;
            doneCnt[i] = 0;
        end
    endtask

    // One clock: update the model from the inputs seen at the edge, then
    // compare every lane shortly after the edge.
    task automatic stepCycle();
        bit ev;
        @(posedge clk);
        cycleNum++;
        for (int i = 0; i < CH; i++) begin
            ev = Edge_H_Level_L ? (Trigger[i] && !prevModel[i]) : Trigger[i];
            prevModel[i] = Trigger[i];
            if (sres) begin
                endCycle[i]  = 0;
                doneModel[i] = 1'b0;
            end else if (ev && Len != 0 && (cycleNum >= endCycle[i] || Retrig_H_Hold_L)) begin
                endCycle[i]  = cycleNum + int'(Len);
                doneModel[i] = 1'b0;
            end else begin
                doneModel[i] = (cycleNum == endCycle[i]);
            end
        end
        #1;
        for (int i = 0; i < CH; i++) begin
            checkOutput($sformatf("Q[%0d]@%0d", i, cycleNum), 32'(Q[i]),
                        32'(cycleNum < endCycle[i]));
            checkOutput($sformatf("Done[%0d]@%0d", i, cycleNum), 32'(Done[i]),
                        32'(doneModel[i]));
            if (Q[i])    hiCnt[i]++;
            if (Done[i]) doneCnt[i]++;
        end
    endtask

    task automatic settle(input int n);
        for (int k = 0; k < n; k++) stepCycle();
    endtask

    // Single-cycle rising edge on one lane with the given length
    task automatic pulseLane(input int lane, input int len);
        Len = W'(len);
        Trigger[lane] = 1'b1;
        stepCycle();
        Trigger[lane] = 1'b0;
    endtask

    task automatic applyStimulus();
        // Power-on reset
        ares_L = 1'b0;
        sres = 1'b0;
        Len = '0;
        Edge_H_Level_L = 1'b1;
        Retrig_H_Hold_L = 1'b0;
        Trigger = '0;
        modelReset();
        clearCounts();
        #3;
        checkOutput("resetQ", 32'(Q), 32'd0);
        checkOutput("resetDone", 32'(Done), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        ares_L = 1'b1;
        settle(2);

        // Asynchronous reset in the middle of a pulse, no clock edge needed
        pulseLane(0, 10);
        settle(2);
        checkOutput("preResetQ0", 32'(Q[0]), 32'd1);
        ares_L = 1'b0;
        #2;
        checkOutput("asyncResetQ", 32'(Q), 32'd0);
        checkOutput("asyncResetDone", 32'(Done), 32'd0);
        modelReset();
        @(posedge clk);
        #1;
        ares_L = 1'b1;
        settle(2);

        // Len=3 after reset
        clearCounts();
        pulseLane(0, 3);
        settle(6);
        checkOutput("len3Width", 32'(hiCnt[0]), 32'd3);
        checkOutput("len3Done", 32'(doneCnt[0]), 32'd1);

        // Hold mode: second edge two cycles later is ignored
        Retrig_H_Hold_L = 1'b0;
        clearCounts();
        pulseLane(1, 5);
        stepCycle();
        pulseLane(1, 5);
        settle(10);
        checkOutput("holdWidth", 32'(hiCnt[1]), 32'd5);
        checkOutput("holdDone", 32'(doneCnt[1]), 32'd1);

        // Retrigger mode: second edge extends the pulse
        Retrig_H_Hold_L = 1'b1;
        clearCounts();
        pulseLane(1, 5);
        stepCycle();
        pulseLane(1, 5);
        settle(10);
        checkOutput("retrigWidth", 32'(hiCnt[1]), 32'd7);
        checkOutput("retrigDone", 32'(doneCnt[1]), 32'd1);

        // Terminal-edge trigger in hold mode chains two pulses with no gap
        Retrig_H_Hold_L = 1'b0;
        clearCounts();
        pulseLane(0, 4);
        settle(3);
        pulseLane(0, 4);
        settle(12);
        checkOutput("terminalWidth", 32'(hiCnt[0]), 32'd8);
        checkOutput("terminalDone", 32'(doneCnt[0]), 32'd1);

        // Synchronous clear mid-pulse with a simultaneous edge
        clearCounts();
        pulseLane(2, 6);
        stepCycle();
        sres = 1'b1;
        Trigger[2] = 1'b1;
        stepCycle();
        checkOutput("sresQ2", 32'(Q[2]), 32'd0);
        Edge_H_Level_L = 1'b0;
        stepCycle();
        checkOutput("sresNoDone", 32'(doneCnt[2]), 32'd0);
        sres = 1'b0;
        stepCycle();
        checkOutput("levelAfterSres", 32'(Q[2]), 32'd1);
        Trigger[2] = 1'b0;
        Edge_H_Level_L = 1'b1;
        settle(10);

        // Length boundaries on lane 3
        clearCounts();
        pulseLane(3, 0);
        settle(5);
        checkOutput("len0Width", 32'(hiCnt[3]), 32'd0);
        checkOutput("len0Done", 32'(doneCnt[3]), 32'd0);
        clearCounts();
        pulseLane(3, 1);
        settle(4);
        checkOutput("len1Width", 32'(hiCnt[3]), 32'd1);
        checkOutput("len1Done", 32'(doneCnt[3]), 32'd1);
        clearCounts();
        pulseLane(3, 255);
        settle(260);
        checkOutput("len255Width", 32'(hiCnt[3]), 32'd255);
        checkOutput("len255Done", 32'(doneCnt[3]), 32'd1);

        // Lane independence with Len changed between accepts
        clearCounts();
        pulseLane(0, 3);
        pulseLane(1, 3);
        pulseLane(2, 7);
        pulseLane(3, 7);
        settle(15);
        checkOutput("indepWidth0", 32'(hiCnt[0]), 32'd3);
        checkOutput("indepWidth1", 32'(hiCnt[1]), 32'd3);
        checkOutput("indepWidth2", 32'(hiCnt[2]), 32'd7);
        checkOutput("indepWidth3", 32'(hiCnt[3]), 32'd7);
        for (int i = 0; i < CH; i++) begin
            checkOutput($sformatf("indepDone%0d", i), 32'(doneCnt[i]), 32'd1);
        end

        // Randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 19) == 0) begin
                case ($urandom_range(0, 4))
                    0: Len = 8'd0;
                    1: Len = 8'd1;
                    2: Len = 8'd2;
                    default: Len = W'($urandom_range(1, 20));
                endcase
            end
            if ($urandom_range(0, 29) == 0) Edge_H_Level_L = ~Edge_H_Level_L;
            if ($urandom_range(0, 29) == 0) Retrig_H_Hold_L = ~Retrig_H_Hold_L;
            sres = ($urandom_range(0, 49) == 0);
            for (int i = 0; i < CH; i++) begin
                if ($urandom_range(0, 3) == 0) Trigger[i] = ~Trigger[i];
            end
            stepCycle();
        end
        sres = 1'b0;
        Trigger = '0;
        settle(25);
    endtask

    initial begin
        applyStimulus();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
